// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Glyphs are active-low {g,f,e,d,c,b,a}; the decimal point is added by the decoder.
package ssd_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [7:0] SSD_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry n is the glyph for hex digit n (F first in the concatenation).
    localparam logic [15:0][6:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble + decimal point to active-low {dp,g,f,e,d,c,b,a} segments.
module hex7seg_dec
    import ssd_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {~i_dp, GLYPH[i_nibble]};

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scan controller with guard gaps and frame-aligned loads.
// Optional SSD_DIM_EN adds a dim_level input that PWM-gates the anode during DRIVE.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int GUARD_CYC = 16
) (
    input  logic        x1,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  blank,
`ifdef SSD_DIM_EN
    input  logic [3:0]  dim_level,
`endif
    output logic [3:0]  anodes,
    output logic [7:0]  SSD,
    output logic        frame_done
);

    localparam int MAXC = (CLK_DIV > GUARD_CYC) ? CLK_DIV : GUARD_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_digit;
    logic [15:0]     r_disp;
    logic [15:0]     r_pend;
    logic [3:0]      r_dpDisp;
    logic [3:0]      r_dpPend;
    logic            r_pendFull;
    logic [3:0]      r_anodes;
    logic [7:0]      r_ssd;
    logic            r_ready;
    logic            r_frameDone;

    state_t          w_stNext;
    logic [CW-1:0]   w_cntNext;
    logic [1:0]      w_digitNext;
    logic            w_commit;
    logic            w_nextCommit;
    logic            w_xfer;
    logic            w_pendFullNext;
    logic [15:0]     w_dispNext;
    logic [3:0]      w_dpNext;
    logic [3:0]      w_nibble;
    logic            w_dp;
    logic [7:0]      w_seg;
    logic            w_anEn;

    // Next-state view; outputs are registered from it so they line up with the state they describe.
    always_comb begin
        w_stNext    = r_state;
        w_cntNext   = r_cnt + CW'(1);
        w_digitNext = r_digit;
        if (r_state == GUARD) begin
            if (r_cnt == GUARD_LAST) begin
                w_stNext  = DRIVE;
                w_cntNext = '0;
            end
        end else if (r_cnt == DRIVE_LAST) begin
            w_stNext    = GUARD;
            w_cntNext   = '0;
            w_digitNext = r_digit + 2'd1;
        end
    end

    assign w_commit       = (r_state == DRIVE) && (r_digit == 2'd3) && (r_cnt == DRIVE_LAST);
    assign w_nextCommit   = (w_stNext == DRIVE) && (w_digitNext == 2'd3) && (w_cntNext == DRIVE_LAST);
    assign w_xfer         = load_valid && r_ready;
    assign w_pendFullNext = w_xfer || (r_pendFull && !w_commit);
    assign w_dispNext     = (w_commit && r_pendFull) ? r_pend : r_disp;
    assign w_dpNext       = (w_commit && r_pendFull) ? r_dpPend : r_dpDisp;
    assign w_nibble       = w_dispNext[{w_digitNext, 2'b00} +: 4];
    assign w_dp           = w_dpNext[w_digitNext];

    hex7seg_dec u_dec (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_seg)
    );

`ifdef SSD_DIM_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwmNext;

    assign w_pwmNext = r_pwm + 4'd1;
    assign w_anEn    = (w_stNext == DRIVE) && !blank[w_digitNext] && (w_pwmNext <= dim_level);

    always_ff @(posedge x1) begin
        if (reset) r_pwm <= 4'd0;
        else       r_pwm <= w_pwmNext;
    end
`else
    assign w_anEn = (w_stNext == DRIVE) && !blank[w_digitNext];
`endif

    // Ready stays high through the commit cycle so a new load can land as the old one commits.
    always_ff @(posedge x1) begin
        if (reset) begin
            r_state     <= GUARD;
            r_cnt       <= '0;
            r_digit     <= 2'd0;
            r_disp      <= 16'h0000;
            r_pend      <= 16'h0000;
            r_dpDisp    <= 4'd0;
            r_dpPend    <= 4'd0;
            r_pendFull  <= 1'b0;
            r_anodes    <= AN_OFF;
            r_ssd       <= SSD_OFF;
            r_ready     <= 1'b1;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stNext;
            r_cnt       <= w_cntNext;
            r_digit     <= w_digitNext;
            if (w_xfer) begin
                r_pend   <= load_value;
                r_dpPend <= load_dp;
            end
            r_pendFull  <= w_pendFullNext;
            r_disp      <= w_dispNext;
            r_dpDisp    <= w_dpNext;
            r_anodes    <= w_anEn ? ~(4'b0001 << w_digitNext) : AN_OFF;
            r_ssd       <= (w_stNext == DRIVE) ? w_seg : SSD_OFF;
            r_ready     <= !w_pendFullNext || w_nextCommit;
            r_frameDone <= w_nextCommit;
        end
    end

    assign anodes     = r_anodes;
    assign SSD        = r_ssd;
    assign load_ready = r_ready;
    assign frame_done = r_frameDone;

endmodule
